// File: rtl/async_fifo_wptr_full_if.sv
// Write-side bundle of the clock-crossing FIFO: the producer request, the unsynchronised read
// pointer, and the write address, Gray pointer, accept, full and level returned by the stage.
interface async_fifo_wptr_full_if #(
  parameter int unsigned ADDR_WIDTH = 4
);

  logic                  wr_en;
  logic [ADDR_WIDTH:0]   rptr_gray_async;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH:0]   wptr_gray;
  logic                  wr_accept;
  logic                  full;
  logic [ADDR_WIDTH:0]   wlevel;

  modport master (
    output wr_en,
    output rptr_gray_async,
    input  waddr,
    input  wptr_gray,
    input  wr_accept,
    input  full,
    input  wlevel
  );

  modport slave (
    input  wr_en,
    input  rptr_gray_async,
    output waddr,
    output wptr_gray,
    output wr_accept,
    output full,
    output wlevel
  );

endinterface

// File: rtl/async_fifo_wptr_full.sv
// Write-domain pointer stage of the clock-crossing FIFO: binary/Gray write pointer, two-flop
// synchroniser for the read Gray pointer, registered full flag and pessimistic fill level.
module async_fifo_wptr_full #(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  async_fifo_wptr_full_if.slave bus
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_gray_q, wgray_d;
  logic [PW-1:0] rq1_q, rq2_q;
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          full_q, full_d;
  logic          wr_accept;

  always_comb begin
    wr_accept = bus.wr_en & ~full_q;
    wbin_d    = wbin_q + PW'(wr_accept);
    wgray_d   = wbin_d ^ (wbin_d >> 1);

    // Gray-to-binary: each bit is the XOR of itself and all higher Gray bits.
    rbin_sync = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      rbin_sync[i] = ^(rq2_q >> i);
    end

    // Full when the next write pointer is exactly one lap ahead of the synced read pointer.
    full_d   = (wgray_d == {~rq2_q[ADDR_WIDTH -: 2], rq2_q[ADDR_WIDTH-2:0]});
    wlevel_d = wbin_d - rbin_sync;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin_q      <= '0;
      wptr_gray_q <= '0;
      rq1_q       <= '0;
      rq2_q       <= '0;
      full_q      <= 1'b0;
      wlevel_q    <= '0;
    end else begin
      wbin_q      <= wbin_d;
      wptr_gray_q <= wgray_d;
      rq1_q       <= bus.rptr_gray_async;
      rq2_q       <= rq1_q;
      full_q      <= full_d;
      wlevel_q    <= wlevel_d;
    end
  end

  assign bus.waddr     = wbin_q[ADDR_WIDTH-1:0];
  assign bus.wptr_gray = wptr_gray_q;
  assign bus.wr_accept = wr_accept;
  assign bus.full      = full_q;
  assign bus.wlevel    = wlevel_q;

endmodule

// File: tb/tb_async_fifo_wptr_full.sv
// Scoreboard bench for async_fifo_wptr_full: an occupancy-based reference model predicts each
// edge's outputs into a queue, which is drained and compared after the edge.
module tb_async_fifo_wptr_full;

  localparam int unsigned AW = 4;
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [PW-1:0] gray;
    logic [AW-1:0] addr;
    logic          full;
    logic [PW-1:0] lvl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  async_fifo_wptr_full_if #(.ADDR_WIDTH(AW)) bus ();

  async_fifo_wptr_full #(.ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  exp_t          exp_q[$];
  logic [PW-1:0] m_wbin = '0;
  logic          m_full = 1'b0;
  logic [PW-1:0] m_s1   = '0;
  logic [PW-1:0] m_s2   = '0;
  logic [PW-1:0] rcnt   = '0;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, expv, $time);
  endtask

  // One write-clock cycle: drive at negedge, predict, then compare after the posedge.
  task automatic step(input logic we, input logic rd);
    logic          acc;
    logic [PW-1:0] wbin_n, lvl, old_gray, occ;
    exp_t          e;
    @(negedge clk);
    if (rd) rcnt = rcnt + 1'b1;
    bus.wr_en           = we;
    bus.rptr_gray_async = bin2gray(rcnt);
    #1;
    acc = we && !m_full;
    check_eq("wr_accept", 32'(bus.wr_accept), 32'(acc));
    wbin_n = m_wbin + PW'(acc);
    lvl    = wbin_n - m_s2;
    exp_q.push_back('{gray: bin2gray(wbin_n), addr: wbin_n[AW-1:0], full: (lvl == PW'(16)),
                      lvl: lvl});
    old_gray = bin2gray(m_wbin);
    m_wbin   = wbin_n;
    m_full   = (lvl == PW'(16));
    m_s2     = m_s1;
    m_s1     = rcnt;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("wptr_gray", 32'(bus.wptr_gray), 32'(e.gray));
    check_eq("waddr", 32'(bus.waddr), 32'(e.addr));
    check_eq("full", 32'(bus.full), 32'(e.full));
    check_eq("wlevel", 32'(bus.wlevel), 32'(e.lvl));
    if (acc) check_eq("gray_one_bit", 32'($countones(bus.wptr_gray ^ old_gray)), 32'd1);
    else check_eq("gray_hold", 32'(bus.wptr_gray), 32'(old_gray));
    occ = m_wbin - rcnt;
    check_eq("no_overflow", 32'(occ <= PW'(16)), 32'd1);
    check_eq("level_pessimistic", 32'(bus.wlevel >= occ), 32'd1);
  endtask

  // Assert reset off the clock edge and require outputs to clear before any edge arrives.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_waddr", 32'(bus.waddr), 32'd0);
    check_eq("rst_wptr_gray", 32'(bus.wptr_gray), 32'd0);
    check_eq("rst_full", 32'(bus.full), 32'd0);
    check_eq("rst_wlevel", 32'(bus.wlevel), 32'd0);
    m_wbin = '0; m_full = 1'b0; m_s1 = '0; m_s2 = '0; rcnt = '0;
    bus.wr_en           = 1'b0;
    bus.rptr_gray_async = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned nw;
    bus.wr_en           = 1'b0;
    bus.rptr_gray_async = '0;

    // Reset release with idle inputs.
    async_reset();
    step(1'b0, 1'b0);
    check_eq("idle_wlevel", 32'(bus.wlevel), 32'd0);

    // Sixteen writes fill the FIFO; waddr walks 0..15.
    for (int i = 0; i < 16; i++) begin
      check_eq("fill_waddr", 32'(bus.waddr), 32'(i));
      step(1'b1, 1'b0);
    end
    check_eq("full_gray", 32'(bus.wptr_gray), 32'b11000);
    check_eq("full_flag", 32'(bus.full), 32'd1);
    check_eq("full_level", 32'(bus.wlevel), 32'd16);
    step(1'b1, 1'b0);
    check_eq("overflow_gray", 32'(bus.wptr_gray), 32'b11000);

    // One read releases full exactly three edges later.
    step(1'b0, 1'b1);
    check_eq("rel_e1_full", 32'(bus.full), 32'd1);
    step(1'b0, 1'b0);
    check_eq("rel_e2_full", 32'(bus.full), 32'd1);
    step(1'b0, 1'b0);
    check_eq("rel_e3_full", 32'(bus.full), 32'd0);
    check_eq("rel_e3_level", 32'(bus.wlevel), 32'd15);
    step(1'b1, 1'b0);
    check_eq("refill_full", 32'(bus.full), 32'd1);

    // Forty writes with reads keeping occupancy low; pointer wraps after write 32.
    async_reset();
    nw = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, (m_wbin - rcnt) >= PW'(8));
      nw++;
      if (nw == 32) begin
        check_eq("wrap_gray", 32'(bus.wptr_gray), 32'd0);
        check_eq("wrap_waddr", 32'(bus.waddr), 32'd0);
      end
    end

    // Reset mid-burst at level 9, then resume from address 0.
    async_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
    check_eq("pre_rst_level", 32'(bus.wlevel), 32'd9);
    bus.wr_en = 1'b1;
    async_reset();
    check_eq("resume_waddr0", 32'(bus.waddr), 32'd0);
    step(1'b1, 1'b0);
    check_eq("resume_waddr1", 32'(bus.waddr), 32'd1);

    // Random traffic with legal single-step read pointer movement.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, (m_wbin != rcnt) && ($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/async_fifo_wptr_full.md
Name: async_fifo_wptr_full

Overview:
- Write-domain pointer and full-flag stage of the clock-crossing FIFOs that feed the CNN line buffers.
- Keeps the binary write counter and drives the Gray-coded write pointer. The bin-to-Gray conversion is done in this stage, inline.
- Synchronises the read-domain Gray pointer into the write clock and derives the full flag, the write address and the fill level.
- Sits between the producer (feature-map writer) and the dual-port RAM / read-pointer stage.

Parameters:
- ADDR_WIDTH, 4, RAM address width. FIFO depth = 2^ADDR_WIDTH. Pointers are ADDR_WIDTH+1 bits. Must be >= 2.

Ports:
- clk, input, 1: write-domain clock.
- rst, input, 1: asynchronous, active-high reset.
- wr_en, input, 1: producer write request.
- rptr_gray_async, input, ADDR_WIDTH+1: read pointer in Gray code, driven from the read clock domain and not yet synchronised.
- waddr, output, ADDR_WIDTH: RAM write address, equal to wbin[ADDR_WIDTH-1:0].
- wptr_gray, output, ADDR_WIDTH+1: registered Gray write pointer, sent to the read domain.
- wr_accept, output, 1: RAM write enable, = wr_en & ~full. Combinational.
- full, output, 1: registered full flag.
- wlevel, output, ADDR_WIDTH+1: registered, pessimistic fill level, range 0..2^ADDR_WIDTH.

Behaviour:
- Reset (async, any time, including mid-burst): wbin, wptr_gray, rq1, rq2, full and wlevel all go to 0. waddr is therefore 0. No pending write survives reset.
- Synchroniser: two flops, rq1 <= rptr_gray_async, rq2 <= rq1. Only rq2 is used in logic.
- Next pointer:
  - wbin_next = wbin + wr_accept, modulo 2^(ADDR_WIDTH+1); wraps naturally.
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - wbin <= wbin_next and wptr_gray <= wgray_next on every edge.
- Full: full <= (wgray_next == {~rq2[ADDR_WIDTH:ADDR_WIDTH-1], rq2[ADDR_WIDTH-2:0]}).
- Fill level:
  - rbin_sync = Gray-to-binary of rq2, where rbin[i] = XOR of rq2[ADDR_WIDTH:i].
  - wlevel <= wbin_next - rbin_sync, modulo 2^(ADDR_WIDTH+1).
- Write path latency:
  - A write accepted at edge k moves waddr, wptr_gray and wlevel immediately after edge k.
  - If that write fills the FIFO, full is asserted after the same edge k. No extra write is ever accepted.
- Read path latency:
  - A change on rptr_gray_async before edge n reaches rq2 after edge n+1.
  - full / wlevel reflect it after edge n+2.
  - full therefore deasserts 3 edges late. This is pessimistic and safe.
- wr_en while full: ignored. wr_accept = 0, no pointer change, no error flag.
- wr_en held high continuously: one accepted write per cycle until full.
- Gray pointer changes by exactly one bit per accepted write, including the wrap from 2^(ADDR_WIDTH+1)-1 to 0.
- wptr_gray is a pure flop output with no combinational path to it, as required for CDC.
- wr_accept is the only combinational output.
- A simultaneous read release and write in the same cycle is handled by the formulas above. No special case is needed.

Test Plan (ADDR_WIDTH=4, depth 16):
- Reset release with wr_en=0, rptr=0 -> waddr=0, wptr_gray=0, full=0, wlevel=0.
- 16 consecutive writes, rptr held 0 ->
  - waddr steps 0..15.
  - wptr_gray after 16 writes = 5'b11000.
  - full=1 after the 16th accept edge; wlevel=16.
  - A 17th wr_en gives wr_accept=0 and no pointer change.
- From full, set rptr_gray_async=5'b00001 (1 read) -> full=0 and wlevel=15 exactly 3 edges later; the next write is accepted and re-asserts full.
- Wrap: 40 writes interleaved with reads that keep the level below 16 -> each wptr_gray step differs in 1 bit; after write 32, wbin wraps to 0 and wptr_gray=0.
- Assert rst mid-burst at wlevel=9 (asynchronously, off the clock edge) -> all outputs 0 immediately, without waiting for a clock edge; writing resumes at waddr=0 after release.
- Random rptr_gray_async changes with a legal 1-bit Gray step per read-clock edge, against a reference model -> full never asserts late, no overflow, wlevel >= true occupancy.
